// File: rtl/ddr3_traffic_gen.sv
// DDR3 MIG traffic generator: writes a patterned block, reads it back and counts mismatches.
// Supports looping passes, a read-return watchdog and first-error address capture.
module ddr3_traffic_gen #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                ui_clk,
  input  logic                ui_rst_n,
  input  logic                test_start,
  input  logic [1:0]          test_mode,
  input  logic                test_loop,
  input  logic [LEN_W-1:0]    test_len,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  input  logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                test_busy,
  output logic [ERR_W-1:0]    error_num,
  output logic                error_done,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned SUM_W = ((ERR_W > LEN_W) ? ERR_W : LEN_W) + 1;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE} state_t;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [LEN_W-1:0] k,
                                                input logic [ADDR_W-1:0] a, input logic [31:0] l);
    logic [31:0] w;
    case (m)
      2'd0:    w = 32'(k);
      2'd1:    w = 32'(a);
      2'd2:    w = 32'h1 << k[4:0];
      default: w = l;
    endcase
    return {LANES{w}};
  endfunction

  state_t             state;
  logic [1:0]         mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   wr_k;
  logic [31:0]        wr_lfsr;
  logic [LEN_W-1:0]   rd_cnt;
  logic [ADDR_W-1:0]  chk_addr;
  logic [31:0]        chk_lfsr;
  logic [WD_W-1:0]    wd_cnt;
  logic               first_seen;

  logic [1:0]         sel_mode;
  logic [ADDR_W-1:0]  sel_base;
  logic [DATA_W-1:0]  beat0_data;
  logic [ADDR_W-1:0]  nxt_addr;
  logic [31:0]        nxt_lfsr;
  logic [DATA_W-1:0]  nxt_data;
  logic [DATA_W-1:0]  exp_data;
  logic               start_pass;
  logic               cmd_done;
  logic               dat_done;
  logic               issue_last;
  logic               rd_active;
  logic               rd_beat;
  logic               rd_bad;
  logic               timeout_hit;
  logic [SUM_W-1:0]   err_sum;
  logic [ERR_W-1:0]   err_timeout;

  assign app_wdf_mask = '0;
  assign app_wdf_end  = app_wdf_wren;

  // Next-beat values for the issue side and expected word for the return side
  always_comb begin
    sel_mode    = (state == S_IDLE) ? test_mode : mode_q;
    sel_base    = (state == S_IDLE) ? base_addr : base_q;
    beat0_data  = pattern(sel_mode, '0, sel_base, LFSR_SEED);
    nxt_addr    = app_addr + ADDR_W'(ADDR_STEP);
    nxt_lfsr    = lfsr_adv(wr_lfsr);
    nxt_data    = pattern(mode_q, wr_k + LEN_W'(1), nxt_addr, nxt_lfsr);
    exp_data    = pattern(mode_q, rd_cnt, chk_addr, chk_lfsr);
    start_pass  = ((state == S_IDLE) && test_start) || ((state == S_DONE) && test_loop);
    cmd_done    = !app_en || app_rdy;
    dat_done    = !app_wdf_wren || app_wdf_rdy;
    issue_last  = (wr_k == len_q - LEN_W'(1));
    rd_active   = (state == S_READ) || (state == S_WAIT_RD);
    rd_beat     = rd_active && app_rd_data_valid && (rd_cnt != len_q);
    rd_bad      = rd_beat && (app_rd_data != exp_data);
    timeout_hit = rd_active && !app_rd_data_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
    err_sum     = SUM_W'(error_num) + SUM_W'(len_q - rd_cnt);
    err_timeout = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      len_q          <= '0;
      base_q         <= '0;
      wr_k           <= '0;
      wr_lfsr        <= LFSR_SEED;
      rd_cnt         <= '0;
      chk_addr       <= '0;
      chk_lfsr       <= LFSR_SEED;
      wd_cnt         <= '0;
      first_seen     <= 1'b0;
      app_addr       <= '0;
      app_cmd        <= CMD_WR;
      app_en         <= 1'b0;
      app_wdf_data   <= '0;
      app_wdf_wren   <= 1'b0;
      test_busy      <= 1'b0;
      error_num      <= '0;
      error_done     <= 1'b0;
      first_err_addr <= '0;
    end else begin
      error_done <= 1'b0;

      // Return checker runs independently of command issue
      if (rd_beat) begin
        rd_cnt   <= rd_cnt + LEN_W'(1);
        chk_addr <= chk_addr + ADDR_W'(ADDR_STEP);
        chk_lfsr <= lfsr_adv(chk_lfsr);
        wd_cnt   <= '0;
        if (rd_bad) begin
          if (error_num != ERR_MAX) error_num <= error_num + ERR_W'(1);
          if (!first_seen) begin
            first_seen     <= 1'b1;
            first_err_addr <= chk_addr;
          end
        end
      end else if (rd_active) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (test_start) begin
            mode_q         <= test_mode;
            len_q          <= (test_len == '0) ? LEN_W'(1) : test_len;
            base_q         <= base_addr;
            error_num      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
            test_busy      <= 1'b1;
          end
        end
        S_WRITE: begin
          if (cmd_done && dat_done) begin
            if (issue_last) begin
              state        <= S_READ;
              wr_k         <= '0;
              app_en       <= 1'b1;
              app_cmd      <= CMD_RD;
              app_addr     <= base_q;
              app_wdf_wren <= 1'b0;
            end else begin
              wr_k         <= wr_k + LEN_W'(1);
              wr_lfsr      <= nxt_lfsr;
              app_addr     <= nxt_addr;
              app_wdf_data <= nxt_data;
              app_en       <= 1'b1;
              app_wdf_wren <= 1'b1;
            end
          end else begin
            if (app_rdy)     app_en       <= 1'b0;
            if (app_wdf_rdy) app_wdf_wren <= 1'b0;
          end
        end
        S_READ: begin
          if (timeout_hit) begin
            app_en     <= 1'b0;
            error_num  <= err_timeout;
            error_done <= 1'b1;
            state      <= S_DONE;
          end else if (app_rdy) begin
            if (issue_last) begin
              app_en <= 1'b0;
              state  <= S_WAIT_RD;
            end else begin
              wr_k     <= wr_k + LEN_W'(1);
              app_addr <= nxt_addr;
            end
          end
        end
        S_WAIT_RD: begin
          if (rd_cnt == len_q) begin
            error_done <= 1'b1;
            state      <= S_DONE;
          end else if (timeout_hit) begin
            error_num  <= err_timeout;
            error_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!test_loop) begin
            state     <= S_IDLE;
            test_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // New pass, either from a start pulse or a looping DONE
      if (start_pass) begin
        state        <= S_WRITE;
        wr_k         <= '0;
        wr_lfsr      <= LFSR_SEED;
        rd_cnt       <= '0;
        chk_addr     <= sel_base;
        chk_lfsr     <= LFSR_SEED;
        wd_cnt       <= '0;
        app_en       <= 1'b1;
        app_cmd      <= CMD_WR;
        app_addr     <= sel_base;
        app_wdf_wren <= 1'b1;
        app_wdf_data <= beat0_data;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Directed bench for ddr3_traffic_gen with a small MIG-like memory model.
module tb_ddr3_traffic_gen;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned ERR_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic                ui_clk;
  logic                ui_rst_n;
  logic                test_start;
  logic [1:0]          test_mode;
  logic                test_loop;
  logic [LEN_W-1:0]    test_len;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W-1:0]   app_rd_data = '0;
  logic                app_rd_data_valid = 1'b0;
  logic                test_busy;
  logic [ERR_W-1:0]    error_num;
  logic                error_done;
  logic [ADDR_W-1:0]   first_err_addr;

  ddr3_traffic_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(8), .LEN_W(LEN_W), .ERR_W(ERR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .ui_clk(ui_clk), .ui_rst_n(ui_rst_n), .test_start(test_start), .test_mode(test_mode),
    .test_loop(test_loop), .test_len(test_len), .base_addr(base_addr),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .test_busy(test_busy), .error_num(error_num),
    .error_done(error_done), .first_err_addr(first_err_addr)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int failures = 0;

  // Memory model state, written only by the model process
  logic [ADDR_W-1:0] wc_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [ADDR_W-1:0] wlog_a[$];
  logic [DATA_W-1:0] wlog_d[$];
  logic [ADDR_W-1:0] rq[$];
  bit                rc_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int rd_issued = 0;
  int cyc = 0, last_v = 0, done_cyc = 0, done_cnt = 0, stab_err = 0;
  logic prev_cmd_pend = 1'b0, prev_dat_pend = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  // Knobs driven by the stimulus
  int drop_idx = -1;
  int corrupt_idx = -1;
  bit inj = 1'b0;

  always @(posedge ui_clk) begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit c;
    cyc++;
    if (app_rd_data_valid) last_v = cyc;
    if (error_done) begin done_cnt++; done_cyc = cyc; end
    if (!ui_rst_n) begin
      wc_q.delete(); wd_q.delete(); rq.delete(); rc_q.delete();
      prev_cmd_pend = 1'b0;
      prev_dat_pend = 1'b0;
      app_rd_data_valid <= 1'b0;
    end else begin
      if (prev_cmd_pend && (!app_en || app_addr !== prev_addr)) stab_err++;
      if (prev_dat_pend && (!app_wdf_wren || app_wdf_data !== prev_data)) stab_err++;
      prev_cmd_pend = app_en && !app_rdy;
      prev_addr     = app_addr;
      prev_dat_pend = app_wdf_wren && !app_wdf_rdy;
      prev_data     = app_wdf_data;
      if (app_en && app_rdy && app_cmd == 3'b000) wc_q.push_back(app_addr);
      if (app_en && app_rdy && app_cmd == 3'b001) begin
        if (rd_issued != drop_idx) begin
          rq.push_back(app_addr);
          rc_q.push_back(rd_issued == corrupt_idx);
        end
        rd_issued++;
      end
      if (app_wdf_wren && app_wdf_rdy) wd_q.push_back(app_wdf_data);
      while (wc_q.size() > 0 && wd_q.size() > 0) begin
        a = wc_q.pop_front();
        d = wd_q.pop_front();
        mem[a] = d;
        wlog_a.push_back(a);
        wlog_d.push_back(d);
      end
      if (inj) begin
        app_rd_data       <= '1;
        app_rd_data_valid <= 1'b1;
      end else if (rq.size() > 0) begin
        a = rq.pop_front();
        c = rc_q.pop_front();
        d = mem.exists(a) ? mem[a] : '0;
        if (c) d[0] = ~d[0];
        app_rd_data       <= d;
        app_rd_data_valid <= 1'b1;
      end else begin
        app_rd_data_valid <= 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ui_clk);
  endtask

  task automatic start(input logic [1:0] m, input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] b);
    @(negedge ui_clk);
    test_mode = m; test_len = len; base_addr = b; test_start = 1'b1;
    @(negedge ui_clk);
    test_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (test_busy && n < budget) begin @(negedge ui_clk); n++; end
    checks++;
    if (test_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_wait: busy=%b after %0d cycles, expected 0", name, test_busy, budget);
    end
  endtask

  task automatic test_reset;
    ui_rst_n = 1'b0; test_start = 1'b0; test_mode = 2'd0; test_loop = 1'b0;
    test_len = '0; base_addr = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick(3);
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, test_busy, error_done} !== 5'b0) begin
      failures++; $display("FAIL reset_ctl: got %b expected 00000", {app_en, app_wdf_wren, app_wdf_end, test_busy, error_done});
    end
    checks++;
    if (app_cmd !== 3'b000) begin failures++; $display("FAIL reset_cmd: got %b expected 000", app_cmd); end
    checks++;
    if (app_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h expected 0", app_addr); end
    checks++;
    if (app_wdf_data !== '0 || app_wdf_mask !== '0) begin
      failures++; $display("FAIL reset_wdata: got %h mask %h expected 0", app_wdf_data, app_wdf_mask);
    end
    checks++;
    if (error_num !== '0 || first_err_addr !== '0) begin
      failures++; $display("FAIL reset_err: got %0d/%h expected 0/0", error_num, first_err_addr);
    end
    ui_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    int w0 = wlog_a.size();
    int d0 = done_cnt;
    logic [ADDR_W-1:0] ea, ga;
    logic [DATA_W-1:0] gd;
    logic [31:0] lane;
    start(2'd0, 16'd4, 28'h0);
    wait_idle("basic", 200);
    checks++;
    if (wlog_a.size() - w0 !== 4) begin failures++; $display("FAIL basic_wcount: got %0d expected 4", wlog_a.size() - w0); end
    for (int k = 0; k < 4; k++) begin
      ea = ADDR_W'(k * 8);
      lane = 32'(k);
      ga = (w0 + k < wlog_a.size()) ? wlog_a[w0 + k] : 'x;
      gd = (w0 + k < wlog_d.size()) ? wlog_d[w0 + k] : 'x;
      checks++;
      if (ga !== ea || gd !== {8{lane}}) begin
        failures++; $display("FAIL basic_beat%0d: got %h/%h expected %h/%h", k, ga, gd, ea, {8{lane}});
      end
    end
    checks++;
    if (error_num !== '0) begin failures++; $display("FAIL basic_errnum: got %0d expected 0", error_num); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure;
    int w0 = wlog_a.size();
    int s0 = stab_err;
    logic [ADDR_W-1:0] ea, ga;
    logic [DATA_W-1:0] gd;
    logic [31:0] lane;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    start(2'd2, 16'd3, 28'h40);
    tick(3);
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    tick(3);
    app_wdf_rdy = 1'b1;
    wait_idle("bp", 200);
    checks++;
    if (wlog_a.size() - w0 !== 3 || wc_q.size() != 0 || wd_q.size() != 0) begin
      failures++; $display("FAIL bp_wcount: got %0d paired, %0d/%0d unpaired expected 3,0/0", wlog_a.size() - w0, wc_q.size(), wd_q.size());
    end
    for (int k = 0; k < 3; k++) begin
      ea = ADDR_W'(28'h40 + k * 8);
      lane = 32'h1 << k;
      ga = (w0 + k < wlog_a.size()) ? wlog_a[w0 + k] : 'x;
      gd = (w0 + k < wlog_d.size()) ? wlog_d[w0 + k] : 'x;
      checks++;
      if (ga !== ea || gd !== {8{lane}}) begin
        failures++; $display("FAIL bp_beat%0d: got %h/%h expected %h/%h", k, ga, gd, ea, {8{lane}});
      end
    end
    checks++;
    if (stab_err - s0 !== 0) begin failures++; $display("FAIL bp_stable: got %0d changes while pending expected 0", stab_err - s0); end
    checks++;
    if (error_num !== '0) begin failures++; $display("FAIL bp_errnum: got %0d expected 0", error_num); end
  endtask

  task automatic test_lfsr;
    int w0 = wlog_d.size();
    logic [31:0] exp_l[3];
    logic [DATA_W-1:0] gd;
    exp_l[0] = 32'hFFFF_FFFF; exp_l[1] = 32'hFFDF_FFFC; exp_l[2] = 32'h7FEF_FFFE;
    start(2'd3, 16'd3, 28'h80);
    wait_idle("lfsr", 200);
    for (int k = 0; k < 3; k++) begin
      gd = (w0 + k < wlog_d.size()) ? wlog_d[w0 + k] : 'x;
      checks++;
      if (gd !== {8{exp_l[k]}}) begin failures++; $display("FAIL lfsr_beat%0d: got %h expected %h", k, gd, {8{exp_l[k]}}); end
    end
    checks++;
    if (error_num !== '0) begin failures++; $display("FAIL lfsr_errnum: got %0d expected 0", error_num); end
  endtask

  task automatic test_corrupt;
    int d0 = done_cnt;
    corrupt_idx = rd_issued + 2;
    start(2'd1, 16'd4, 28'h100);
    wait_idle("corrupt", 200);
    corrupt_idx = -1;
    checks++;
    if (error_num !== 16'd1) begin failures++; $display("FAIL corrupt_errnum: got %0d expected 1", error_num); end
    checks++;
    if (first_err_addr !== 28'h110) begin failures++; $display("FAIL corrupt_addr: got %h expected 110", first_err_addr); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL corrupt_done: got %0d pulses expected 1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int d0 = done_cnt;
    drop_idx = rd_issued + 3;
    start(2'd0, 16'd4, 28'h0);
    wait_idle("timeout", 300);
    drop_idx = -1;
    checks++;
    if (error_num !== 16'd1) begin failures++; $display("FAIL timeout_errnum: got %0d expected 1", error_num); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL timeout_done: got %0d pulses expected 1", done_cnt - d0); end
    // 16 idle cycles after the last returned beat, then one DONE cycle
    checks++;
    if (done_cyc - last_v !== 17) begin failures++; $display("FAIL timeout_gap: got %0d cycles expected 17", done_cyc - last_v); end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    int w0 = wlog_a.size();
    int n = 0;
    logic [ADDR_W-1:0] ga4, ga5;
    logic [DATA_W-1:0] gd5;
    test_loop = 1'b1;
    start(2'd0, 16'd2, 28'h200);
    tick(2);
    test_mode = 2'd1; base_addr = 28'h300; test_start = 1'b1;
    tick(1);
    test_start = 1'b0;
    while (done_cnt < d0 + 2 && n < 400) begin @(negedge ui_clk); n++; end
    checks++;
    if (done_cnt < d0 + 2) begin failures++; $display("FAIL loop_wait: got %0d pulses expected 2 within 400 cycles", done_cnt - d0); end
    test_loop = 1'b0;
    wait_idle("loop", 200);
    checks++;
    if (done_cnt - d0 !== 3) begin failures++; $display("FAIL loop_done: got %0d pulses expected 3", done_cnt - d0); end
    checks++;
    if (wlog_a.size() - w0 !== 6) begin failures++; $display("FAIL loop_wcount: got %0d expected 6", wlog_a.size() - w0); end
    ga4 = (w0 + 4 < wlog_a.size()) ? wlog_a[w0 + 4] : 'x;
    ga5 = (w0 + 5 < wlog_a.size()) ? wlog_a[w0 + 5] : 'x;
    gd5 = (w0 + 5 < wlog_d.size()) ? wlog_d[w0 + 5] : 'x;
    checks++;
    if (ga4 !== 28'h200 || ga5 !== 28'h208 || gd5 !== {8{32'd1}}) begin
      failures++; $display("FAIL loop_pass3: got %h,%h/%h expected 200,208/%h", ga4, ga5, gd5, {8{32'd1}});
    end
    checks++;
    if (error_num !== '0) begin failures++; $display("FAIL loop_errnum: got %0d expected 0", error_num); end
    // Stray read data while idle
    inj = 1'b1;
    tick(1);
    inj = 1'b0;
    tick(3);
    checks++;
    if (error_num !== '0 || done_cnt - d0 !== 3) begin
      failures++; $display("FAIL idle_rdata: got err %0d pulses %0d expected 0/3", error_num, done_cnt - d0);
    end
  endtask

  task automatic test_wrap_reset;
    int w0 = wlog_a.size();
    int d0;
    logic [ADDR_W-1:0] ga0, ga1;
    start(2'd0, 16'd2, 28'hFFF_FFF8);
    wait_idle("wrap", 200);
    ga0 = (w0 < wlog_a.size()) ? wlog_a[w0] : 'x;
    ga1 = (w0 + 1 < wlog_a.size()) ? wlog_a[w0 + 1] : 'x;
    checks++;
    if (ga0 !== 28'hFFF_FFF8 || ga1 !== 28'h0) begin failures++; $display("FAIL wrap_addr: got %h,%h expected fffff8,0", ga0, ga1); end
    checks++;
    if (error_num !== '0) begin failures++; $display("FAIL wrap_errnum: got %0d expected 0", error_num); end
    app_rdy = 1'b0;
    start(2'd2, 16'd4, 28'h80);
    tick(2);
    d0 = done_cnt;
    checks++;
    if (app_en !== 1'b1 || test_busy !== 1'b1) begin failures++; $display("FAIL rst_pre: got en %b busy %b expected 1/1", app_en, test_busy); end
    ui_rst_n = 1'b0;
    #1;
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, test_busy, error_done} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_ctl: got %b expected 00000", {app_en, app_wdf_wren, app_wdf_end, test_busy, error_done});
    end
    checks++;
    if (app_addr !== '0 || app_wdf_data !== '0 || app_cmd !== 3'b000) begin
      failures++; $display("FAIL rst_mid_data: got %h/%h/%b expected 0/0/000", app_addr, app_wdf_data, app_cmd);
    end
    tick(2);
    ui_rst_n = 1'b1;
    app_rdy = 1'b1;
    tick(10);
    checks++;
    if (done_cnt !== d0 || test_busy !== 1'b0 || app_en !== 1'b0) begin
      failures++; $display("FAIL rst_after: got pulses %0d busy %b en %b expected 0/0/0", done_cnt - d0, test_busy, app_en);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_lfsr();
    test_corrupt();
    test_timeout();
    test_back_to_back();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/ddr3_traffic_gen.md
DDR3_TRAFFIC_GEN -- requirements
Module: ddr3_traffic_gen

Interface
REQ-001 Parameter ADDR_W, 28, app_addr width.
REQ-002 Parameter DATA_W, 256, app data width; multiple of 32.
REQ-003 Parameter ADDR_STEP, 8, app_addr increment per command.
REQ-004 Parameter LEN_W, 16, width of test_len.
REQ-005 Parameter ERR_W, 16, width of error_num.
REQ-006 Parameter TIMEOUT, 4096, idle-cycle limit while awaiting read data.
REQ-007 ui_clk  in  1  sole clock; all logic on rising edge.
REQ-008 ui_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 test_start  in  1  one-cycle start pulse.
REQ-010 test_mode  in  2  pattern: 0 INC, 1 ADDR, 2 WALK, 3 LFSR; sampled at start.
REQ-011 test_loop  in  1  repeat passes while high; sampled at end of each pass.
REQ-012 test_len  in  LEN_W  commands per pass; sampled at start; 0 treated as 1.
REQ-013 base_addr  in  ADDR_W  first address; sampled at start.
REQ-014 app_addr/app_cmd/app_en  out  ADDR_W/3/1  MIG command port; write=3'b000, read=3'b001.
REQ-015 app_rdy, app_wdf_rdy  in  1 each  MIG ready flags.
REQ-016 app_wdf_data/app_wdf_mask/app_wdf_wren/app_wdf_end  out  DATA_W/DATA_W/8/1/1  write data port; mask always 0; end equals wren.
REQ-017 app_rd_data/app_rd_data_valid  in  DATA_W/1  read return.
REQ-018 test_busy  out  1  high from start acceptance to pass completion.
REQ-019 error_num  out  ERR_W  mismatching read beats, saturating.
REQ-020 error_done  out  1  one-cycle pulse at end of every pass.
REQ-021 first_err_addr  out  ADDR_W  address of first mismatch since start.

Function
REQ-022 FSM states IDLE, WRITE, READ, WAIT_RD, DONE; IDLE->WRITE on test_start; test_start ignored outside IDLE.
REQ-023 Start acceptance clears error_num and first_err_addr, latches mode/len/base, sets test_busy next cycle.
REQ-024 Beat k (0..len-1) uses app_addr = base_addr + k*ADDR_STEP, wrapping modulo 2^ADDR_W.
REQ-025 Pattern per 32-bit lane: INC = k; ADDR = app_addr zero-extended; WALK = 1<<(k mod 32); LFSR = state of x^32+x^22+x^2+x+1 Galois LFSR seeded 32'hFFFF_FFFF each pass, advanced once per beat; all lanes identical.
REQ-026 WRITE: app_en and app_wdf_wren asserted with beat k; command handshake = app_en&app_rdy, data handshake = app_wdf_wren&app_wdf_rdy; each deasserts independently once taken; beat advances the cycle after both taken; stable outputs while pending.
REQ-027 WRITE->READ after beat len-1 fully taken; READ issues len read commands, advancing on app_en&app_rdy.
REQ-028 Read checking independent of issue: separate return counter and pattern generator; each app_rd_data_valid beat compared to expected full DATA_W word.
REQ-029 Mismatch increments error_num (hold at 2^ERR_W-1); first mismatch since start captures its address into first_err_addr.
REQ-030 READ->WAIT_RD after last read command taken; ->DONE when returned count equals len.
REQ-031 Watchdog: in READ/WAIT_RD, counter of cycles without app_rd_data_valid; at TIMEOUT, add outstanding beats (len minus returned) to error_num, saturating, then ->DONE.
REQ-032 DONE lasts one cycle: error_done=1; if test_loop ->WRITE (error_num kept, LFSR reseeded), else ->IDLE with test_busy=0 next cycle.
REQ-033 Read data arriving in IDLE is ignored.

Reset
REQ-034 ui_rst_n low asynchronously forces IDLE; app_en, app_wdf_wren, app_wdf_end, test_busy, error_done =0; app_cmd=3'b000; app_addr, app_wdf_data, error_num, first_err_addr, all counters =0; LFSR=32'hFFFF_FFFF.
REQ-035 Reset mid-pass abandons outstanding commands; no error_done pulse.

Verification
REQ-036 Ideal model, mode 0, len=4, base=0: writes at 0,8,16,24 with lanes 0..3, reads match -> error_num=0, one error_done, busy deasserts.
REQ-037 app_rdy low 3 cycles with app_wdf_rdy high, then reverse -> each beat written exactly once, data/address stable while pending.
REQ-038 Mode 1, model corrupts bit 0 of beat 2, base=0x100 -> error_num=1, first_err_addr=0x110.
REQ-039 Model drops last of 4 reads, TIMEOUT=16 -> error_num=1 after 16 idle cycles, error_done pulses.
REQ-040 test_loop high, len=2, 3 passes -> three error_done pulses, error_num=0; start pulse while busy ignored.
REQ-041 base=2^ADDR_W-8, len=2 -> second address 0; ui_rst_n low mid-WRITE -> all outputs at reset values immediately.
